seg7_scan_controller: RTL and testbench

//  Time-multiplexes one 4-bit hex-to-7-segment decoder across the four common-anode

---
 rtl/seg7_scan_controller.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_controller.sv
// Four-digit multiplexed 7-segment scanner with a double-buffered display value and per-slot anti-ghost blanking.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (and their decimal points).
module seg7_scan_controller #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [15:0] Value,
    input  logic [3:0]  Dp,
    input  logic [3:0]  Digit_En,
    input  logic        Load,
    output logic        Load_Ack,
    output logic [3:0]  Nibble,
    output logic [3:0]  An,
    output logic        Dp_n,
    output logic        Frame_Start
);

    // state    | meaning
    // ST_BLANK | start of slot, all anodes off while the decoder settles
    // ST_SHOW  | current digit's anode on if the digit is visible
    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    localparam logic [19:0] CNT_LAST  = 20'(REFRESH_DIV - 1);
    localparam logic [19:0] BLANK_END = 20'(BLANK_CYC);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] active_q, active_d;
    logic [3:0]  active_dp_q, active_dp_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic        pending_q, pending_d;
    logic        xfer_q, xfer_d;
    logic [3:0]  nibble_q, nibble_d;
    logic [3:0]  an_q, an_d;
    logic        dp_n_q, dp_n_d;
    logic        load_ack_q, load_ack_d;
    logic        frame_start_q, frame_start_d;

    logic        wrap;
    logic        boundary;
    logic        visible;
    logic [3:0]  lz_ok;

    always_comb begin
        wrap     = (cnt_q == CNT_LAST);
        boundary = wrap && (idx_q == 2'd3);
        cnt_d    = wrap ? 20'd0 : cnt_q + 20'd1;
        idx_d    = wrap ? idx_q + 2'd1 : idx_q;

        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pending_d   = pending_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        // A Load on the boundary cycle still moves the older shadow; the new value waits a frame.
        if (boundary && pending_q) begin
            active_d    = shadow_q;
            active_dp_d = shadow_dp_q;
        end
        if (Load) begin
            shadow_d    = Value;
            shadow_dp_d = Dp;
            pending_d   = 1'b1;
        end else if (boundary) begin
            pending_d = 1'b0;
        end

        xfer_d        = boundary && pending_q;
        load_ack_d    = xfer_q;
        frame_start_d = (cnt_q == 20'd0) && (idx_q == 2'd0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (cnt_d >= BLANK_END) state_d = ST_SHOW;
            ST_SHOW:  if (cnt_d == 20'd0)     state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        lz_ok[3] = |active_d[15:12];
        lz_ok[2] = lz_ok[3] | (|active_d[11:8]);
        lz_ok[1] = lz_ok[2] | (|active_d[7:4]);
        lz_ok[0] = 1'b1;
`else
        lz_ok = 4'b1111;
`endif
        visible = Digit_En[idx_d] && lz_ok[idx_d];

        nibble_d = (cnt_d == 20'd0) ? active_d[{idx_d, 2'b00} +: 4] : nibble_q;
        an_d     = 4'b1111;
        dp_n_d   = 1'b1;
        if ((state_d == ST_SHOW) && visible) begin
            an_d[idx_d] = 1'b0;
            dp_n_d      = ~active_dp_d[idx_d];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= ST_BLANK;
            cnt_q         <= 20'd0;
            idx_q         <= 2'd0;
            active_q      <= 16'd0;
            active_dp_q   <= 4'd0;
            shadow_q      <= 16'd0;
            shadow_dp_q   <= 4'd0;
            pending_q     <= 1'b0;
            xfer_q        <= 1'b0;
            nibble_q      <= 4'd0;
            an_q          <= 4'b1111;
            dp_n_q        <= 1'b1;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            active_dp_q   <= active_dp_d;
            shadow_q      <= shadow_d;
            shadow_dp_q   <= shadow_dp_d;
            pending_q     <= pending_d;
            xfer_q        <= xfer_d;
            nibble_q      <= nibble_d;
            an_q          <= an_d;
            dp_n_q        <= dp_n_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign Load_Ack    = load_ack_q;
    assign Nibble      = nibble_q;
    assign An          = an_q;
    assign Dp_n        = dp_n_q;
    assign Frame_Start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with REFRESH_DIV=8, BLANK_CYC=2.
module tb_seg7_scan_controller;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [15:0] Value = 16'd0;
    logic [3:0]  Dp = 4'd0;
    logic [3:0]  Digit_En = 4'b1111;
    logic        Load = 1'b0;
    logic        Load_Ack;
    logic [3:0]  Nibble;
    logic [3:0]  An;
    logic        Dp_n;
    logic        Frame_Start;

    int checks = 0;
    int errors = 0;

    seg7_scan_controller #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Value(Value), .Dp(Dp), .Digit_En(Digit_En),
        .Load(Load), .Load_Ack(Load_Ack), .Nibble(Nibble), .An(An), .Dp_n(Dp_n),
        .Frame_Start(Frame_Start)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [15:0] exp_an;
        logic [15:0] exp_nib;
        logic [3:0]  exp_dpn;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        Value = v;
        Dp = d;
        Load = 1'b1;
        step();
        Load = 1'b0;
    endtask

    task automatic wait_ack(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (Load_Ack) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_fs(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (Frame_Start) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Starts at count 1 of digit 0, ends at count 1 of digit 0 of the next frame.
    task automatic scan_frame(input vec_t v);
        for (int d = 0; d < 4; d++) begin
            step();
            chk($sformatf("an_show_first_d%0d", d), 16'(An), 16'(v.exp_an[4*d +: 4]));
            chk($sformatf("dpn_show_d%0d", d), 16'(Dp_n), 16'(v.exp_dpn[d]));
            chk($sformatf("nib_show_d%0d", d), 16'(Nibble), 16'(v.exp_nib[4*d +: 4]));
            repeat (5) step();
            chk($sformatf("an_show_last_d%0d", d), 16'(An), 16'(v.exp_an[4*d +: 4]));
            step();
            chk($sformatf("an_blank_d%0d", (d + 1) % 4), 16'(An), 16'hF);
            chk($sformatf("dpn_blank_d%0d", (d + 1) % 4), 16'(Dp_n), 16'h1);
            chk($sformatf("nib_blank_d%0d", (d + 1) % 4), 16'(Nibble),
                16'(v.exp_nib[4*((d + 1) % 4) +: 4]));
            step();
        end
        chk("frame_start_next", 16'(Frame_Start), 16'h1);
        chk("no_ack_next", 16'(Load_Ack), 16'h0);
    endtask

    always @(negedge Clk) begin
        checks++;
        if ($countones(~An) > 1) begin
            errors++;
            $display("FAIL an_onehot got %b want at most one low at %0t", An, $time);
        end
    end

    initial begin
        bit ok;
        int acks;
        int n;
        int bad;
        int lit;
        logic [3:0] nib_at_ack;

`ifdef LEADING_ZERO_BLANK_EN
        vecs[0] = '{16'hA3C5, 4'b0100, 4'b1111, 16'h7BDE, 16'hA3C5, 4'b1011};
        vecs[1] = '{16'h0040, 4'b0000, 4'b1111, 16'hFFDE, 16'h0040, 4'b1111};
        vecs[2] = '{16'h0000, 4'b1001, 4'b1111, 16'hFFFE, 16'h0000, 4'b1110};
`else
        vecs[0] = '{16'hA3C5, 4'b0100, 4'b1111, 16'h7BDE, 16'hA3C5, 4'b1011};
        vecs[1] = '{16'h0040, 4'b0000, 4'b1111, 16'h7BDE, 16'h0040, 4'b1111};
        vecs[2] = '{16'h0000, 4'b1001, 4'b1111, 16'h7BDE, 16'h0000, 4'b0110};
`endif
        vecs[3] = '{16'hBEEF, 4'b1111, 4'b0101, 16'hFBFE, 16'hBEEF, 4'b1010};
        vecs[4] = '{16'h1234, 4'b0010, 4'b1010, 16'h7FDF, 16'h1234, 4'b1101};

        // Reset and first slots after release
        repeat (5) step();
        chk("rst_an", 16'(An), 16'hF);
        chk("rst_dpn", 16'(Dp_n), 16'h1);
        chk("rst_nib", 16'(Nibble), 16'h0);
        chk("rst_ack", 16'(Load_Ack), 16'h0);
        chk("rst_fs", 16'(Frame_Start), 16'h0);
        Rst_n = 1'b1;
        step();
        chk("rel_fs_c1", 16'(Frame_Start), 16'h1);
        chk("rel_an_c1", 16'(An), 16'hF);
        step();
        chk("rel_fs_c2", 16'(Frame_Start), 16'h0);
        chk("rel_an_c2", 16'(An), 16'hE);
        repeat (5) step();
        chk("rel_an_c7", 16'(An), 16'hE);
        step();
        chk("rel_an_c8", 16'(An), 16'hF);
        step();
        chk("rel_an_c9", 16'(An), 16'hF);
        step();
`ifdef LEADING_ZERO_BLANK_EN
        chk("rel_an_c10", 16'(An), 16'hF);
`else
        chk("rel_an_c10", 16'(An), 16'hD);
`endif

        // Table-driven: load mid-frame, check one full frame after the transfer
        for (int i = 0; i < 5; i++) begin
            Digit_En = vecs[i].en;
            load(vecs[i].value, vecs[i].dp);
            chk("ack_not_immediate", 16'(Load_Ack), 16'h0);
            wait_ack(ok);
            chk($sformatf("ack_seen_v%0d", i), 16'(ok), 16'h1);
            chk("ack_with_fs", 16'(Frame_Start), 16'h1);
            chk("ack_an_blank", 16'(An), 16'hF);
            scan_frame(vecs[i]);
        end

        // Two loads in one frame give a single ack and the later value
        Digit_En = 4'b1111;
        load(16'h1111, 4'b0000);
        load(16'h2222, 4'b0000);
        acks = 0;
        nib_at_ack = 4'h0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (Load_Ack) begin
                acks++;
                nib_at_ack = Nibble;
            end
        end
        chk("double_load_acks", 16'(acks), 16'd1);
        chk("double_load_nib", 16'(nib_at_ack), 16'h2);

        // Load on the boundary cycle lands one frame later
        wait_fs(ok);
        chk("sync_fs_boundary", 16'(ok), 16'h1);
        load(16'h3333, 4'b0000);
        repeat (29) step();
        load(16'h4444, 4'b0000);
        chk("bnd_no_ack_c0", 16'(Load_Ack), 16'h0);
        chk("bnd_nib_c0", 16'(Nibble), 16'h3);
        step();
        chk("bnd_ack1", 16'(Load_Ack), 16'h1);
        chk("bnd_fs1", 16'(Frame_Start), 16'h1);
        wait_ack(ok);
        chk("bnd_ack2_seen", 16'(ok), 16'h1);
        chk("bnd_nib2", 16'(Nibble), 16'h4);

        // Disabled digits still take their slots
        Digit_En = 4'b0101;
        wait_fs(ok);
        chk("sync_fs_en", 16'(ok), 16'h1);
        n = 0;
        bad = 0;
        lit = 0;
        do begin
            step();
            n++;
            if (An == 4'b1101 || An == 4'b0111) bad++;
            if (An != 4'b1111) lit++;
        end while (!Frame_Start && n < 100);
        chk("frame_period", 16'(n), 16'd32);
        chk("disabled_lit", 16'(bad), 16'd0);
        chk("enabled_lit_cycles", 16'(lit), 16'd12);

        // Reset mid-SHOW of digit 2 with a load pending
        Digit_En = 4'b1111;
        wait_fs(ok);
        chk("sync_fs_rst", 16'(ok), 16'h1);
        load(16'h5555, 4'b0000);
        repeat (18) step();
        chk("pre_rst_an_d2", 16'(An), 16'hB);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_rst_an", 16'(An), 16'hF);
        chk("async_rst_nib", 16'(Nibble), 16'h0);
        repeat (3) step();
        Rst_n = 1'b1;
        step();
        chk("rst2_fs_c1", 16'(Frame_Start), 16'h1);
        acks = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (Load_Ack) acks++;
            if (Nibble != 4'h0) bad++;
        end
        chk("rst2_no_ack", 16'(acks), 16'd0);
        chk("rst2_nib_zero", 16'(bad), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
